// File: rtl/fsm3_multi_seq_detector.sv
// ----------------------------------------------------------------------------
// fsm3_multi_seq_detector
//
// Serial pattern monitor. Watches a 1-bit stream, oldest bit first, for any of
// the sequences 1100, 11001 and 01011. Overlapping matches are reported. The
// flag is registered: it is high for exactly the cycle after the clock edge
// that samples the final bit of a match.
//
// Each state holds the longest suffix of the bit history that is a proper
// prefix of one of the patterns.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | no useful history (after reset)
//   S0    | history ends in "0"
//   S01   | history ends in "01"
//   S010  | history ends in "010"
//   S0101 | history ends in "0101"
//   S1    | history is exactly "1"
//   S11   | history ends in "11"
//   S110  | history ends in "110"
//   S1100 | history ends in "1100" (1100 just matched)
//
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset; forces IDLE and out = 0
//   in    - serial data bit, sampled every rising clk edge
//   out   - registered detection flag, one cycle per completed match
// ----------------------------------------------------------------------------
module fsm3_multi_seq_detector (
    input  logic clk,
    input  logic rstn,
    input  logic in,
    output logic out
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        S0    = 4'd1,
        S01   = 4'd2,
        S010  = 4'd3,
        S0101 = 4'd4,
        S1    = 4'd5,
        S11   = 4'd6,
        S110  = 4'd7,
        S1100 = 4'd8
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            out   <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= hit;
        end
    end

    // Next state and the match flag for the bit being sampled this cycle.
    // The state reached after a match keeps the matched suffix so that
    // overlapping occurrences are still found.
    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = in ? S1 : S0;
            end
            S0: begin
                state_nxt = in ? S01 : S0;
            end
            S01: begin
                state_nxt = in ? S11 : S010;
            end
            S010: begin
                state_nxt = in ? S0101 : S0;
            end
            S0101: begin
                // 01011 completes; the trailing "11" starts a 1100 attempt
                state_nxt = in ? S11 : S010;
                hit       = in;
            end
            S1: begin
                state_nxt = in ? S11 : S0;
            end
            S11: begin
                state_nxt = in ? S11 : S110;
            end
            S110: begin
                // 1100 completes on a 0; on a 1 the "01" suffix is kept
                state_nxt = in ? S01 : S1100;
                hit       = ~in;
            end
            S1100: begin
                // 11001 completes on a 1, leaving "01" for a 01011 attempt
                state_nxt = in ? S01 : S0;
                hit       = in;
            end
            default: begin
                state_nxt = IDLE;
                hit       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm3_multi_seq_detector.sv
module tb_fsm3_multi_seq_detector;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic in   = 1'b0;
    logic out;

    int n_vec = 0;
    int n_err = 0;

    fsm3_multi_seq_detector dut (
        .clk  (clk),
        .rstn (rstn),
        .in   (in),
        .out  (out)
    );

    always #5 clk = ~clk;

    // Reference model: remember the last four bits since reset and decide a
    // match directly from the pattern strings.
    logic [3:0] hist;
    int         hist_len;
    logic       exp_out;

    function automatic logic model_hit(input logic [3:0] h, input int len, input logic b);
        logic [4:0] w;
        w = {h, b};
        return (len >= 3 && w[3:0] == 4'b1100) ||
               (len >= 4 && (w == 5'b11001 || w == 5'b01011));
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist     <= 4'b0;
            hist_len <= 0;
            exp_out  <= 1'b0;
        end else begin
            exp_out  <= model_hit(hist, hist_len, in);
            hist     <= {hist[2:0], in};
            hist_len <= (hist_len < 4) ? hist_len + 1 : 4;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        n_vec++;
        if (out !== exp_out) begin
            n_err++;
            $display("FAIL cycle_compare t=%0t out=%b model=%b", $time, out, exp_out);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with rstn released.
    task automatic do_reset();
        rstn = 1'b0;
        in   = 1'bx;
        #1;
        check("reset_out", out, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        in   = 1'b0;
    endtask

    // Called at a negedge; applies one bit and checks the registered flag.
    task automatic step(input string name, input logic b, input logic e);
        in = b;
        @(posedge clk);
        #1;
        check(name, out, e);
        check("model_pin", exp_out, e);
        @(negedge clk);
    endtask

    task automatic run_dir(input string name, input logic [31:0] bits, input int n,
                           input logic [31:0] mask);
        logic [31:0] bv;
        logic [31:0] mv;
        bv = bits;
        mv = mask;
        do_reset();
        for (int i = 0; i < n; i++)
            step(name, bv[n-1-i], mv[n-1-i]);
    endtask

    initial begin
        @(negedge clk);

        run_dir("rep_1100",   32'b110011001100, 12, 32'b000110011001);
        run_dir("rep_01011",  32'b0101101011,   10, 32'b0000100001);
        run_dir("b2b_11001",  32'b11001,         5, 32'b00011);
        run_dir("pre_1101",   32'b11101011,      8, 32'b00000001);
        run_dir("no_hit",     32'b000111,        6, 32'b000000);

        // Reset pulse in the middle of 1,1,0 discards the history.
        do_reset();
        step("mid_rst", 1'b1, 1'b0);
        step("mid_rst", 1'b1, 1'b0);
        step("mid_rst", 1'b0, 1'b0);
        rstn = 1'b0;
        in   = 1'bx;
        #1;
        check("mid_rst_async", out, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        step("mid_rst_after", 1'b0, 1'b0);
        step("mid_rst_after", 1'b0, 1'b0);

        // Reset asserted between edges while the flag is high clears it at once.
        do_reset();
        step("async_pre", 1'b1, 1'b0);
        step("async_pre", 1'b1, 1'b0);
        step("async_pre", 1'b0, 1'b0);
        in = 1'b0;
        @(posedge clk);
        #1;
        check("async_high", out, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_clear", out, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic with occasional resets, checked every cycle.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                in = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
